// File: rtl/bmap_scanout_pkg.sv
// Shared constants and state encoding for the bitmap scan-out path.
// The address width is shared with the CPU-side bitmap store logic.
package bmap_scanout_pkg;
    localparam int BMAP_W         = 1536;
    localparam int BEAT_W         = 16;
    localparam int BEATS_PER_BMAP = BMAP_W / BEAT_W;
    localparam int ADDR_W         = 16;
    localparam int CNT_W          = 8;
    localparam int BEAT_CNT_W     = $clog2(BEATS_PER_BMAP);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_CAPT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/bmap_scanout_if.sv
// Bitmap memory read port plus the outgoing beat stream.
// master = scan-out block, slave = memory / back-end environment.
interface bmap_scanout_if;
    import bmap_scanout_pkg::*;

    logic [ADDR_W-1:0] mem_rdaddress;
    logic              mem_rden;
    logic [BMAP_W-1:0] mem_q;
    logic [BEAT_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              pix_frame_end;

    modport master (
        output mem_rdaddress, mem_rden, pix_data, pix_valid, pix_last, pix_frame_end,
        input  mem_q, pix_ready
    );

    modport slave (
        input  mem_rdaddress, mem_rden, pix_data, pix_valid, pix_last, pix_frame_end,
        output mem_q, pix_ready
    );
endinterface

// File: rtl/bmap_scanout_serializer.sv
// Wide-to-narrow shift register: loads one bitmap word, emits it LSB beat first
// and flags the final beat of the word.
module bmap_scanout_serializer
    import bmap_scanout_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [BMAP_W-1:0] i_load_data,
    input  logic              i_shift,
    output logic [BEAT_W-1:0] o_beat,
    output logic              o_last
);
    logic [BMAP_W-1:0]     r_shift;
    logic [BEAT_CNT_W-1:0] r_beat;

    // Load wins over shift so a buffered word can replace the final beat in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_beat  <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_beat  <= '0;
        end else if (i_load) begin
            r_shift <= i_load_data;
            r_beat  <= '0;
        end else if (i_shift) begin
            r_shift <= r_shift >> BEAT_W;
            r_beat  <= r_beat + BEAT_CNT_W'(1);
        end else begin
            r_shift <= r_shift;
            r_beat  <= r_beat;
        end
    end

    assign o_beat = r_shift[BEAT_W-1:0];
    assign o_last = (r_beat == BEAT_CNT_W'(BEATS_PER_BMAP - 1));
endmodule

// File: rtl/bmap_scanout.sv
// Bitmap scan-out: fetches a run of bitmap words and streams them as 16-bit beats.
// Define BMAP_SCANOUT_PREFETCH_EN to add a holding buffer for a gapless stream.
module bmap_scanout
    import bmap_scanout_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    bmap_scanout_if.master    bus
);
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remain;
    logic              w_hs;
    logic              w_last;
    logic              w_last_hs;
    logic              w_more;
    logic              w_load;
    logic              w_load_buf;
    logic              w_pf_issue;
    logic              w_pf_ready;
    logic [BMAP_W-1:0] w_pf_data;
    logic [BMAP_W-1:0] w_load_data;
    logic [BEAT_W-1:0] w_beat;

    assign w_hs      = (r_state == ST_SHIFT) && bus.pix_ready;
    assign w_last_hs = w_hs && w_last;
    // r_remain counts the bitmap currently being streamed.
    assign w_more    = (r_remain != CNT_W'(1));

`ifdef BMAP_SCANOUT_PREFETCH_EN
    logic [BMAP_W-1:0] r_pf_buf;
    logic              r_pf_full;
    logic              r_pf_pend;

    assign w_pf_issue = (r_state == ST_SHIFT) && w_more && !r_pf_full && !r_pf_pend;
    assign w_pf_ready = r_pf_full;
    assign w_pf_data  = r_pf_buf;

    // Holding buffer: capture the read issued last cycle; drop it once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pf_buf  <= '0;
            r_pf_full <= 1'b0;
            r_pf_pend <= 1'b0;
        end else if (i_abort) begin
            r_pf_buf  <= '0;
            r_pf_full <= 1'b0;
            r_pf_pend <= 1'b0;
        end else if (w_last_hs) begin
            r_pf_buf  <= r_pf_buf;
            r_pf_full <= 1'b0;
            r_pf_pend <= 1'b0;
        end else if (r_pf_pend) begin
            r_pf_buf  <= bus.mem_q;
            r_pf_full <= 1'b1;
            r_pf_pend <= 1'b0;
        end else begin
            r_pf_buf  <= r_pf_buf;
            r_pf_full <= r_pf_full;
            r_pf_pend <= w_pf_issue;
        end
    end
`else
    assign w_pf_issue = 1'b0;
    assign w_pf_ready = 1'b0;
    assign w_pf_data  = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and serializer load control; abort overrides everything.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_buf = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = (i_count == '0) ? ST_DONE : ST_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ:  w_next = ST_CAPT;
            ST_CAPT: begin
                w_next = ST_SHIFT;
                w_load = 1'b1;
            end
            ST_SHIFT: begin
                if (w_last_hs && !w_more) begin
                    w_next = ST_DONE;
                end else if (w_last_hs && w_pf_ready) begin
                    w_next     = ST_SHIFT;
                    w_load     = 1'b1;
                    w_load_buf = 1'b1;
                end else if (w_last_hs) begin
                    w_next = ST_REQ;
                end else begin
                    w_next = ST_SHIFT;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (i_abort) begin
            w_next     = ST_IDLE;
            w_load     = 1'b0;
            w_load_buf = 1'b0;
        end else begin
            w_next = w_next;
        end
    end

    // Run bookkeeping: address and bitmaps remaining, latched on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (i_abort) begin
            r_addr   <= r_addr;
            r_remain <= r_remain;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_addr   <= i_base_addr;
            r_remain <= i_count;
        end else if (w_last_hs) begin
            r_addr   <= w_more ? (r_addr + ADDR_W'(1)) : r_addr;
            r_remain <= r_remain - CNT_W'(1);
        end else begin
            r_addr   <= r_addr;
            r_remain <= r_remain;
        end
    end

    assign w_load_data = w_load_buf ? w_pf_data : bus.mem_q;

    bmap_scanout_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (i_abort),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_shift     (w_hs && !i_abort),
        .o_beat      (w_beat),
        .o_last      (w_last)
    );

    assign o_busy            = (r_state != ST_IDLE);
    assign o_done            = (r_state == ST_DONE);
    assign bus.mem_rden      = (r_state == ST_REQ) || w_pf_issue;
    assign bus.mem_rdaddress = (r_state == ST_REQ) ? r_addr :
                               (w_pf_issue ? (r_addr + ADDR_W'(1)) : '0);
    assign bus.pix_valid     = (r_state == ST_SHIFT);
    assign bus.pix_data      = bus.pix_valid ? w_beat : '0;
    assign bus.pix_last      = bus.pix_valid && w_last;
    assign bus.pix_frame_end = bus.pix_valid && w_last && !w_more;
endmodule

// File: tb/tb_bmap_scanout.sv
// Randomized self-checking bench for bmap_scanout; expected beats come from a
// per-address beat formula, independent of the RTL's shift-register view.
module tb_bmap_scanout;
    import bmap_scanout_pkg::*;

`ifdef BMAP_SCANOUT_PREFETCH_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [CNT_W-1:0]  i_count = '0;
    logic              o_busy;
    logic              o_done;

    int          n_chk = 0;
    int          n_err = 0;
    int          pat_mode = 0;
    logic [15:0] seed = 16'h0000;

    bmap_scanout_if bus();

    bmap_scanout dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] beat_val(input logic [15:0] a, input int i);
        logic [15:0] r;
        if (pat_mode == 0) r = 16'(i);
        else r = (a * 16'h9E37) ^ (16'(i) * 16'h79B9) ^ seed;
        return r;
    endfunction

    function automatic logic [BMAP_W-1:0] make_word(input logic [15:0] a);
        logic [BMAP_W-1:0] w;
        w = '0;
        for (int i = 0; i < BEATS_PER_BMAP; i++) w[i*16 +: 16] = beat_val(a, i);
        return w;
    endfunction

    // Memory model with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_rden) bus.mem_q <= make_word(bus.mem_rdaddress);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1. rmode: 0 ready always, 1 toggle (0 first), 2 random.
    task automatic run_scan(input logic [15:0] base, input int cnt, input int rmode, input int abort_beat);
        logic [15:0] exp_data[$];
        bit          exp_last[$];
        bit          exp_fe[$];
        logic [15:0] exp_addr[$];
        logic [15:0] a;
        logic [17:0] prev;
        int cyc, first_v, last_hs_cyc, hs, total, shift_cycles;
        bit fin, aborted, prev_stall, rdy;
        for (int b = 0; b < cnt; b++) begin
            a = base + 16'(b);
            exp_addr.push_back(a);
            for (int i = 0; i < BEATS_PER_BMAP; i++) begin
                exp_data.push_back(beat_val(a, i));
                exp_last.push_back(i == BEATS_PER_BMAP - 1);
                exp_fe.push_back((b == cnt - 1) && (i == BEATS_PER_BMAP - 1));
            end
        end
        total = cnt * BEATS_PER_BMAP;
        i_base_addr = base; i_count = CNT_W'(cnt); i_start = 1'b1; bus.pix_ready = 1'b0;
        cyc = 0; first_v = -1; last_hs_cyc = 0; hs = 0; shift_cycles = 0;
        fin = 0; aborted = 0; prev_stall = 0; prev = '0;
        while (!fin && cyc < 4000) begin
            @(posedge clk); #1; cyc++;
            i_start = 1'b0; i_abort = 1'b0; bus.pix_ready = 1'b0;
            if (aborted) begin
                check("abort_busy", 32'(o_busy), 32'd0);
                check("abort_valid", 32'(bus.pix_valid), 32'd0);
                check("abort_done", 32'(o_done), 32'd0);
                fin = 1;
            end else begin
                if (bus.mem_rden) begin
                    if (exp_addr.size() == 0) check("extra_read", 32'd1, 32'd0);
                    else check("rd_addr", 32'(bus.mem_rdaddress), 32'(exp_addr.pop_front()));
                end
                if (o_done) begin
                    check("done_beats", 32'(hs), 32'(total));
                    check("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
                    fin = 1;
                end else if (bus.pix_valid) begin
                    shift_cycles++;
                    if (first_v < 0) begin
                        first_v = cyc;
                        check("first_valid_cyc", 32'(cyc), 32'd3);
                    end
                    if (prev_stall)
                        check("stall_hold", 32'({bus.pix_data, bus.pix_last, bus.pix_frame_end}), 32'(prev));
                    case (rmode)
                        0:       rdy = 1'b1;
                        1:       rdy = ((cyc - first_v) % 2) == 1;
                        default: rdy = 1'($urandom_range(0, 1));
                    endcase
                    if (rmode == 2) begin
                        i_start = 1'($urandom_range(0, 1));
                        i_count = CNT_W'($urandom);
                        i_base_addr = 16'($urandom);
                    end
                    bus.pix_ready = rdy;
                    if (rdy && hs == abort_beat) begin
                        i_abort = 1'b1;
                        aborted = 1;
                    end else if (rdy) begin
                        if (exp_data.size() == 0) check("extra_beat", 32'd1, 32'd0);
                        else begin
                            check("pix_data", 32'(bus.pix_data), 32'(exp_data.pop_front()));
                            check("pix_last", 32'(bus.pix_last), 32'(exp_last.pop_front()));
                            check("pix_frame_end", 32'(bus.pix_frame_end), 32'(exp_fe.pop_front()));
                        end
                        hs++;
                        last_hs_cyc = cyc;
                    end
                    prev_stall = !rdy;
                    prev = {bus.pix_data, bus.pix_last, bus.pix_frame_end};
                end else begin
                    if (prev_stall) check("valid_dropped", 32'd0, 32'd1);
                    prev_stall = 0;
                end
            end
        end
        i_start = 1'b0; i_abort = 1'b0; bus.pix_ready = 1'b0;
        if (!fin) check("timeout", 32'd0, 32'd1);
        if (abort_beat < 0 && rmode == 0)
            check("stream_span", 32'(last_hs_cyc - first_v + 1), 32'(total + (cnt - 1) * GAP));
        if (abort_beat < 0 && rmode == 1)
            check("shift_cycles", 32'(shift_cycles), 32'(cnt * 2 * BEATS_PER_BMAP));
        if (aborted) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("abort_no_done", 32'(o_done), 32'd0);
            end
        end else begin
            @(posedge clk); #1;
            check("idle_after_done", 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        bus.pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_rden", 32'(bus.mem_rden), 32'd0);
        check("rst_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_data", 32'(bus.pix_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(o_busy), 32'd0);

        pat_mode = 0;
        run_scan(16'h0010, 1, 0, -1);
        run_scan(16'h0010, 1, 1, -1);

        pat_mode = 1;
        seed = 16'($urandom);
        run_scan(16'hFFFF, 2, 0, -1);

        // Empty run: one DONE cycle, no reads, no beats.
        i_count = 8'd0; i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        check("cnt0_busy", 32'(o_busy), 32'd1);
        check("cnt0_done", 32'(o_done), 32'd1);
        check("cnt0_rden", 32'(bus.mem_rden), 32'd0);
        check("cnt0_valid", 32'(bus.pix_valid), 32'd0);
        @(posedge clk); #1;
        check("cnt0_idle", 32'(o_busy), 32'd0);
        check("cnt0_done_end", 32'(o_done), 32'd0);

        run_scan(16'($urandom), 2, 0, 40);
        run_scan(16'h0100, 1, 0, -1);

        // Asynchronous reset in the middle of streaming.
        i_base_addr = 16'h0200; i_count = 8'd2; i_start = 1'b1; bus.pix_ready = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.pix_valid), 32'd1);
        #1; rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_valid", 32'(bus.pix_valid), 32'd0);
        check("async_rst_data", 32'(bus.pix_data), 32'd0);
        check("async_rst_last", 32'(bus.pix_last), 32'd0);
        #1; rst = 1'b0; bus.pix_ready = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(o_busy), 32'd0);

        seed = 16'($urandom);
        run_scan(16'($urandom), 3, 0, -1);

        for (int k = 0; k < 5; k++) begin
            int c;
            int ab;
            seed = 16'($urandom);
            c = int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c * BEATS_PER_BMAP - 1)) : -1;
            run_scan(16'($urandom), c, 2, ab);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bmap_scanout.md
Name: bmap_scanout

Overview:
- Read-side consumer of the bitmap data memory. The CPU writes that memory through its bitmap store path; this block reads it back.
- On a start command it fetches a run of consecutive 1536-bit bitmap words from the memory read port.
- Each word is serialized into 16-bit beats on a valid/ready stream toward the audio/display back end.
- Sits beside the CPU and shares the bitmap memory read port, which has 1-cycle registered read latency.

Parameters:
- BMAP_W, 1536, bits per bitmap memory word.
- BEAT_W, 16, bits per output beat; BMAP_W must be a multiple of BEAT_W.
- ADDR_W, 16, bitmap memory address width.
- CNT_W, 8, width of the bitmap-count field.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  1-cycle command pulse; honoured only in IDLE.
- base_addr  in  ADDR_W  first bitmap address; sampled on an accepted start.
- count  in  CNT_W  number of bitmaps to stream; sampled on an accepted start.
- abort  in  1  synchronous cancel.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  1-cycle pulse after the last beat is accepted.
- mem_rdaddress  out  ADDR_W  bitmap memory read address.
- mem_rden  out  1  read enable.
- mem_q  in  BMAP_W  read data, valid the cycle after mem_rden.
- pix_data  out  BEAT_W  output beat.
- pix_valid  out  1  beat valid.
- pix_ready  in  1  downstream accept.
- pix_last  out  1  marks the final beat of each bitmap.
- pix_frame_end  out  1  marks the final beat of the whole run.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; address, beat and bitmap counters 0; shift register 0.
- FSM states: IDLE, REQ, CAPT, SHIFT, DONE.
  - IDLE: start=1 latches base_addr/count. count==0 → DONE; otherwise → REQ. start is ignored while busy.
  - REQ: mem_rden=1, mem_rdaddress=current address → CAPT.
  - CAPT: shift_reg<=mem_q, beat counter<=0 → SHIFT.
  - SHIFT: pix_valid=1, pix_data=shift_reg[BEAT_W-1:0]. A handshake is pix_valid&pix_ready.
    - On a handshake the register shifts right by BEAT_W and the beat counter increments.
    - On the handshake of the last beat (beat index BMAP_W/BEAT_W-1 = 95): decrement remaining; if remaining was 1 → DONE, else address+1 → REQ.
  - DONE: done=1 for exactly one cycle → IDLE.
- pix_data, pix_last and pix_frame_end stay stable while pix_valid&~pix_ready. pix_valid never drops without a handshake, except on abort or reset.
- pix_last=1 on beat 95. pix_frame_end=1 on beat 95 of the final bitmap.
- Beat ordering: beat 0 = bitmap bits [15:0], ascending.
- Latency: start sampled at cycle 0; REQ at 1; CAPT at 2; first pix_valid at 3. Without prefetch there is a 2-cycle bubble (REQ, CAPT) between bitmaps.
- Address arithmetic is modulo 2^ADDR_W: base 0xFFFF with count 2 reads 0xFFFF then 0x0000.
- abort=1 in any state: IDLE on the next edge, pix_valid=0, done not pulsed. abort has priority over start and over a simultaneous handshake.
- rst asserted mid-run: immediate return to reset values, regardless of clk.
- mem_rden is asserted only in REQ, or in the prefetch case below.

Optional Feature:
- Macro BMAP_SCANOUT_PREFETCH_EN.
- Defined:
  - A second BMAP_W holding buffer is added.
  - While in SHIFT with more bitmaps remaining and the buffer empty, the block issues the next read and captures it one cycle later.
  - On the last-beat handshake, the buffer loads into the shift register directly, so the stream is gapless: next beat is valid the following cycle.
  - abort or rst clears the buffer.
- Undefined: behaviour exactly as above, with the 2-cycle inter-bitmap bubble.

Decomposition:
- Shared package holds:
  - State enum (IDLE, REQ, CAPT, SHIFT, DONE).
  - BMAP_W, BEAT_W, and BEATS_PER_BMAP = BMAP_W/BEAT_W.
  - The bitmap memory address width constant, shared with the CPU side.
- One sub-module is natural: bmap_serializer, the BMAP_W→BEAT_W shift register with load/shift and beat counter plus last flag. The FSM and address logic stay in the top.

Test Plan:
- Reset, then start base=0x0010 count=1, mem[0x0010]=pattern with beat i = i, pix_ready=1 → first valid at cycle 3; beats 0x0000..0x005F in order; pix_last and pix_frame_end on beat 95; done pulses one cycle later.
- Same stimulus with pix_ready toggling 1-0 each cycle → identical beat sequence; data held stable while stalled; 192 cycles of SHIFT.
- Wrap-around: count=2, base=0xFFFF → read addresses 0xFFFF then 0x0000; 192 beats; pix_frame_end only on beat 191.
- count=0 → busy for 1 cycle, done pulse, no mem_rden, no pix_valid.
- abort asserted on beat 40 together with pix_ready → next cycle busy=0, pix_valid=0, no done. A later start runs normally. Async rst mid-SHIFT clears outputs without a clk edge.
- With BMAP_SCANOUT_PREFETCH_EN and count=3, pix_ready=1 → 288 consecutive valid cycles with no bubble. Without the macro → two 2-cycle gaps.
